ndp_stream_feeder: RTL and testbench
====================================

Name: ndp_stream_feeder

Overview:
Upstream stage of the even-byte property accelerator. Given a base address and a word count, it fetches 32-bit words from a memory read port into a small prefetch FIFO. It feeds the words one at a time into the accelerator over its start/data_in/done/data_out handshake. At the end it reports the accelerator's final cumulative count as the job result.

Parameters:
ADDR_W, 32, byte-address width of memory port; addresses wrap modulo 2^ADDR_W
LEN_W, 16, width of word-count field
FIFO_DEPTH, 4, prefetch FIFO entries and max outstanding reads; power of 2, >=2

Ports:
clk_i  in  1  clock, all logic on rising edge
arst_i  in  1  asynchronous active-high reset
cfg_start_i  in  1  job start; sampled only in IDLE
cfg_base_i  in  ADDR_W  byte base address, captured with cfg_start_i
cfg_len_i  in  LEN_W  number of 32-bit words, captured with cfg_start_i
busy_o  out  1  high from the cycle after accept until done_o
done_o  out  1  one-cycle job-complete pulse
result_o  out  32  final accelerator count, valid from done_o until next accept
mem_req_o  out  1  read request; one word per cycle when high
mem_addr_o  out  ADDR_W  request byte address
mem_rvalid_i  in  1  read data valid; in-order, any latency >=1
mem_rdata_i  in  32  read data
acc_clear_o  out  1  one-cycle registered pulse; integration ORs it into the accelerator's reset
acc_start_o  out  1  one-cycle start pulse to accelerator
acc_data_o  out  32  word to accelerator; held stable from start until done
acc_done_i  in  1  accelerator done; accelerator contract: deasserts within 1 cycle of acc_start_o
acc_data_i  in  32  accelerator cumulative count

Behaviour:
- Reset: all outputs 0. FSM to IDLE. FIFO emptied. Issue/feed/outstanding counters 0.
- FSM IDLE -> CLEAR -> RUN -> FINISH -> IDLE.
- IDLE:
  - cfg_start_i=1 latches base and len, then goes to CLEAR.
  - mem_rvalid_i with zero outstanding reads is dropped; this covers responses that arrive after a mid-job reset.
- CLEAR (1 cycle):
  - acc_clear_o=1, busy_o=1, result_q<=0.
  - Next state is FINISH if len==0, else RUN.
- RUN, issue side:
  - mem_req_o=1 while issued<len and outstanding+fifo_count<FIFO_DEPTH.
  - mem_addr_o = base + 4*issued, truncated to ADDR_W bits.
  - issued increments each cycle mem_req_o=1 (no grant; memory always accepts).
- RUN, receive side:
  - mem_rvalid_i pushes mem_rdata_i into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO never overflows.
  - A simultaneous request and response in the same cycle is legal.
- RUN, feed sub-FSM:
  - F_IDLE: if FIFO non-empty, pop, register acc_data_o, pulse acc_start_o for 1 cycle, go to F_BLANK.
  - F_BLANK: acc_done_i ignored for 1 cycle.
  - F_WAIT: on acc_done_i=1, capture result_q<=acc_data_i, increment fed, return to F_IDLE.
  - Minimum spacing between acc_start_o pulses is 3 cycles.
- RUN -> FINISH when fed==len.
- FINISH (1 cycle): done_o=1, busy_o=0, result_o=result_q. Then IDLE.
- result_o holds its value until the next CLEAR.
- cfg_start_i while busy is ignored and not queued.
- Arithmetic: issued and fed are LEN_W bits. A job of len = 2^LEN_W-1 completes without counter overflow.
- Mid-job reset: everything returns to the reset state immediately. No done_o is produced for the aborted job.

Decomposition:
- Shared package/header (alongside constants.vh):
  - WORD_W=32
  - FSM state encodings (S_IDLE, S_CLEAR, S_RUN, S_FINISH)
  - feed-state encodings (F_IDLE, F_BLANK, F_WAIT)
  - default FIFO_DEPTH
- Sub-module ndp_sync_fifo:
  - parameterised width/depth
  - ptr-based, count output
  - async active-high reset on clk_i/arst_i
  - push/pop same cycle allowed

Test Plan:
- Job base=0x100, len=3, memory 0x100..0x108 = 01020304, 05060708, 090A0B0C, behavioural accelerator model -> reads at 0x100, 0x104, 0x108 in order; three acc_start_o pulses; done_o once; result_o=6.
- len=0 -> acc_clear_o pulse, no mem_req_o, no acc_start_o, done_o exactly 2 cycles after the start cycle, result_o=0.
- Back-pressure: len=8, memory latency 6 cycles, accelerator done latency 4 -> outstanding+fifo never exceeds 4, no FIFO overflow, result_o equals the model's even-byte count.
- Address wrap: ADDR_W=8, base=0xF8, len=4 -> addresses F8, FC, 00, 04.
- Reset mid-job after 2 of 5 words, late rvalid after reset, then new job len=1 word 01030507 -> late data dropped, result_o=0, done_o once.
- cfg_start_i pulsed while busy, then a job with word 02040608 -> second start ignored, result_o=4, exactly one done_o per accepted job.

Source files
------------

// File: rtl/ndp_stream_feeder_pkg.sv
// Shared constants and state encodings for the even-byte accelerator stream feeder.
package ndp_stream_feeder_pkg;

  localparam int WORD_W             = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_BLANK = 2'd1,
    F_WAIT  = 2'd2
  } feed_e;

endpackage

// File: rtl/ndp_sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count; push and pop may coincide.
module ndp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ndp_stream_feeder.sv
// Fetches a block of words from memory into a prefetch FIFO and streams them
// one at a time into the even-byte accelerator, reporting its final count.
module ndp_stream_feeder
  import ndp_stream_feeder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cfg_start_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WORD_W-1:0] result_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              acc_clear_o,
  output logic              acc_start_o,
  output logic [WORD_W-1:0] acc_data_o,
  input  logic              acc_done_i,
  input  logic [WORD_W-1:0] acc_data_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  feed_e             feed_q, feed_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  fed_q, fed_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [WORD_W-1:0] acc_data_q, acc_data_d;
  logic              acc_start_q, acc_start_d;

  logic              mem_req;
  logic              rsp_ok;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [WORD_W-1:0] fifo_rdata;

  // A response with nothing outstanding belongs to an aborted job and is dropped.
  assign rsp_ok = mem_rvalid_i && (outst_q != '0);

  ndp_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (rsp_ok),
    .wdata_i (mem_rdata_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    feed_d      = feed_q;
    base_d      = base_q;
    len_d       = len_q;
    fed_d       = fed_q;
    result_d    = result_q;
    acc_data_d  = acc_data_q;
    acc_start_d = 1'b0;
    fifo_pop    = 1'b0;

    // Credits cover words in flight plus words parked in the FIFO.
    mem_req  = (state_q == S_RUN) && (issued_q < len_q) &&
               (({1'b0, outst_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    issued_d = issued_q + LEN_W'(mem_req);
    outst_d  = outst_q + CW'(mem_req) - CW'(rsp_ok);

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          base_d   = cfg_base_i;
          len_d    = cfg_len_i;
          issued_d = '0;
          fed_d    = '0;
          feed_d   = F_IDLE;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        result_d = '0;
        state_d  = (len_q == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (fed_q == len_q) begin
          state_d = S_FINISH;
        end else begin
          unique case (feed_q)
            F_IDLE: begin
              if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                acc_data_d  = fifo_rdata;
                acc_start_d = 1'b1;
                feed_d      = F_BLANK;
              end
            end
            F_BLANK: feed_d = F_WAIT;
            F_WAIT: begin
              if (acc_done_i) begin
                result_d = acc_data_i;
                fed_d    = fed_q + LEN_W'(1);
                feed_d   = F_IDLE;
              end
            end
            default: feed_d = F_IDLE;
          endcase
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      feed_q      <= F_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      fed_q       <= '0;
      outst_q     <= '0;
      result_q    <= '0;
      acc_data_q  <= '0;
      acc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      feed_q      <= feed_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      fed_q       <= fed_d;
      outst_q     <= outst_d;
      result_q    <= result_d;
      acc_data_q  <= acc_data_d;
      acc_start_q <= acc_start_d;
    end
  end

  assign busy_o      = (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done_o      = (state_q == S_FINISH);
  assign acc_clear_o = (state_q == S_CLEAR);
  assign result_o    = result_q;
  assign mem_req_o   = mem_req;
  assign mem_addr_o  = base_q + ADDR_W'({issued_q, 2'b00});
  assign acc_start_o = acc_start_q;
  assign acc_data_o  = acc_data_q;

endmodule

// File: tb/tb_ndp_stream_feeder.sv
// Scoreboard bench: directed jobs against memory and accelerator models; a
// second 8-bit-address instance runs in lockstep to exercise address wrap.
module tb_ndp_stream_feeder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [15:0] cfg_len;
  logic        rvalid;
  logic [31:0] rdata;
  logic        acc_done;
  logic [31:0] acc_out;

  logic        busy0, done0, req0, clear0, start0;
  logic [31:0] result0, addr0, adata0;
  logic        busy1, done1, req1, clear1, start1;
  logic [31:0] result1, adata1;
  logic [7:0]  addr1;

  ndp_stream_feeder dut (
    .clk_i(clk), .arst_i(arst), .cfg_start_i(cfg_start), .cfg_base_i(cfg_base),
    .cfg_len_i(cfg_len), .busy_o(busy0), .done_o(done0), .result_o(result0),
    .mem_req_o(req0), .mem_addr_o(addr0), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .acc_clear_o(clear0), .acc_start_o(start0), .acc_data_o(adata0),
    .acc_done_i(acc_done), .acc_data_i(acc_out)
  );

  ndp_stream_feeder #(.ADDR_W(8)) dut8 (
    .clk_i(clk), .arst_i(arst), .cfg_start_i(cfg_start), .cfg_base_i(cfg_base[7:0]),
    .cfg_len_i(cfg_len), .busy_o(busy1), .done_o(done1), .result_o(result1),
    .mem_req_o(req1), .mem_addr_o(addr1), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .acc_clear_o(clear1), .acc_start_o(start1), .acc_data_o(adata1),
    .acc_done_i(acc_done), .acc_data_i(acc_out)
  );

  typedef struct { int due; logic [31:0] data; } rsp_t;

  logic [31:0] mem [256];
  rsp_t        pipe [$];
  logic [31:0] exp_addr [$];
  logic [7:0]  exp_addr8 [$];
  logic [31:0] exp_data [$];
  logic [31:0] exp_res [$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mem_lat = 1, acc_lat = 1, acc_timer = 0;
  int acc_cnt = 0;
  int done_cnt = 0, start_cnt = 0, clear_cnt = 0, req_cnt = 0, max_infl = 0;
  int start_cyc = 0;
  bit chk_gap = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int even_bytes(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!w[8*i]) n++;
    return n;
  endfunction

  // Models and monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (pipe.size() != 0 && pipe[0].due <= cyc) begin
      r      = pipe.pop_front();
      rvalid = 1'b1;
      rdata  = r.data;
    end else begin
      rvalid = 1'b0;
    end
    if (!arst) begin
      if (cfg_start && !busy0 && !done0) start_cyc = cyc;
      if (req0) begin
        req_cnt++;
        r.due  = cyc + mem_lat;
        r.data = mem[addr0[9:2]];
        pipe.push_back(r);
        check("req0_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) check("mem_addr", addr0, exp_addr.pop_front());
      end
      if (req1) begin
        check("req8_expected", 64'(exp_addr8.size() != 0), 64'd1);
        if (exp_addr8.size() != 0) check("mem_addr8", addr1, exp_addr8.pop_front());
      end
      if (start0) begin
        start_cnt++;
        check("start_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) check("acc_data", adata0, exp_data.pop_front());
      end
      if (req0) begin
        if (req_cnt - start_cnt > max_infl) max_infl = req_cnt - start_cnt;
        check("inflight_le_depth", 64'(req_cnt - start_cnt <= 4), 64'd1);
      end
      if (clear0) clear_cnt++;
      if (done0) begin
        done_cnt++;
        check("busy_at_done", busy0, 0);
        check("done_expected", 64'(exp_res.size() != 0), 64'd1);
        if (exp_res.size() != 0) check("result", result0, exp_res.pop_front());
        if (chk_gap) check("len0_done_gap", cyc - start_cyc, 2);
      end
      check("lockstep8", {busy1, done1, clear1, start1, req1, adata1, result1},
                         {busy0, done0, clear0, start0, req0, adata0, result0});
      if (clear0) begin
        acc_cnt = 0; acc_out = '0; acc_done = 1'b0; acc_timer = 0;
      end else if (start0) begin
        acc_cnt += even_bytes(adata0);
        acc_done  = 1'b0;
        acc_timer = acc_lat;
      end else if (acc_timer > 0) begin
        acc_timer--;
        if (acc_timer == 0) begin
          acc_done = 1'b1;
          acc_out  = 32'(acc_cnt);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctrl"}, {busy0, done0, req0, clear0, start0}, 0);
    check({nm, "_result"}, result0, 0);
    check({nm, "_acc_data"}, adata0, 0);
    check({nm, "_addr"}, addr0, 0);
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] len);
    @(posedge clk); #1;
    req_cnt = 0; start_cnt = 0;
    cfg_base = base; cfg_len = len; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < 500) begin @(posedge clk); n++; end
    if (done_cnt == d0) check({nm, "_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      exp_addr.push_back(a);
      exp_addr8.push_back(a[7:0]);
    end
  endtask

  initial begin
    int d0, c0, n;
    arst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
    rvalid = 1'b0; rdata = '0; acc_done = 1'b0; acc_out = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    arst = 1'b0;

    // Job 1: basic three-word job.
    mem[8'h40] = 32'h01020304; mem[8'h41] = 32'h05060708; mem[8'h42] = 32'h090A0B0C;
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104); exp_addr.push_back(32'h108);
    exp_addr8.push_back(8'h00); exp_addr8.push_back(8'h04); exp_addr8.push_back(8'h08);
    exp_data.push_back(32'h01020304); exp_data.push_back(32'h05060708);
    exp_data.push_back(32'h090A0B0C);
    exp_res.push_back(32'd6);
    d0 = done_cnt;
    start_job(32'h100, 16'd3);
    check("j1_busy", busy0, 1);
    wait_done(d0, "j1");
    check("j1_done_count", done_cnt - d0, 1);
    check("j1_starts", start_cnt, 3);
    check("j1_result_hold", result0, 32'd6);

    // Job 2: zero length.
    exp_res.push_back(32'd0);
    d0 = done_cnt; c0 = clear_cnt; chk_gap = 1'b1;
    start_job(32'h200, 16'd0);
    wait_done(d0, "j2");
    chk_gap = 1'b0;
    check("j2_clear_pulses", clear_cnt - c0, 1);
    check("j2_reqs", req_cnt, 0);
    check("j2_starts", start_cnt, 0);

    // Job 3: slow memory and slow accelerator.
    mem_lat = 6; acc_lat = 4;
    mem[0] = 32'h00000000; mem[1] = 32'h11111111; mem[2] = 32'h22222222;
    mem[3] = 32'h12345678; mem[4] = 32'h01010101; mem[5] = 32'h02020202;
    mem[6] = 32'h0F0E0D0C; mem[7] = 32'hFFFFFFFE;
    push_addrs(32'h0, 8);
    for (int i = 0; i < 8; i++) exp_data.push_back(mem[i]);
    exp_res.push_back(32'd19);
    d0 = done_cnt; max_infl = 0;
    start_job(32'h0, 16'd8);
    wait_done(d0, "j3");
    check("j3_done_count", done_cnt - d0, 1);
    check("j3_max_inflight", max_infl, 4);

    // Job 4: address wrap on the 8-bit instance.
    mem_lat = 1; acc_lat = 1;
    mem[8'h3E] = 32'h02020202; mem[8'h3F] = 32'h03030303;
    mem[8'h40] = 32'h04040404; mem[8'h41] = 32'h05050505;
    exp_addr.push_back(32'hF8); exp_addr.push_back(32'hFC);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    exp_addr8.push_back(8'hF8); exp_addr8.push_back(8'hFC);
    exp_addr8.push_back(8'h00); exp_addr8.push_back(8'h04);
    exp_data.push_back(32'h02020202); exp_data.push_back(32'h03030303);
    exp_data.push_back(32'h04040404); exp_data.push_back(32'h05050505);
    exp_res.push_back(32'd8);
    d0 = done_cnt;
    start_job(32'hF8, 16'd4);
    wait_done(d0, "j4");
    check("j4_done_count", done_cnt - d0, 1);

    // Job 5: reset mid-job, late responses, then a fresh one-word job.
    mem_lat = 6; acc_lat = 1;
    for (int i = 0; i < 5; i++) mem[8'hC0 + i] = 32'h02020202;
    push_addrs(32'h300, 5);
    for (int i = 0; i < 5; i++) exp_data.push_back(32'h02020202);
    d0 = done_cnt;
    start_job(32'h300, 16'd5);
    n = 0;
    while (start_cnt < 2 && n < 200) begin @(posedge clk); n++; end
    check("j5_reached_two_words", 64'(start_cnt >= 2), 64'd1);
    repeat (3) @(posedge clk);
    #1 arst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midreset");
    exp_addr.delete(); exp_addr8.delete(); exp_data.delete(); exp_res.delete();
    arst = 1'b0;
    n = 0;
    while (pipe.size() != 0 && n < 100) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1 check("j5_idle_after_late", {busy0, req0, start0}, 0);
    check("j5_no_done_for_abort", done_cnt - d0, 0);
    mem[8'h10] = 32'h01030507;
    exp_addr.push_back(32'h40); exp_addr8.push_back(8'h40);
    exp_data.push_back(32'h01030507);
    exp_res.push_back(32'd0);
    d0 = done_cnt;
    start_job(32'h40, 16'd1);
    wait_done(d0, "j5b");
    check("j5b_done_count", done_cnt - d0, 1);
    check("j5b_starts", start_cnt, 1);

    // Job 6: start pulsed while busy is ignored.
    mem_lat = 1; acc_lat = 3;
    mem[8'h20] = 32'h02040608;
    exp_addr.push_back(32'h80); exp_addr8.push_back(8'h80);
    exp_data.push_back(32'h02040608);
    exp_res.push_back(32'd4);
    d0 = done_cnt;
    start_job(32'h80, 16'd1);
    @(posedge clk); #1;
    cfg_base = 32'h500; cfg_len = 16'd2; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(d0, "j6");
    repeat (20) @(posedge clk);
    #1 check("j6_done_count", done_cnt - d0, 1);
    check("j6_reqs", req_cnt, 1);
    check("j6_busy_after", busy0, 0);
    check("j6_result_hold", result0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
